mem_port_arbiter: RTL

- Shares the single data-memory port (cs/rw/addr/wdata/rdata) between two masters.
- Master 0 is the instruction control unit's load/store path; master 1 is a secondary master (program loader / debug port).
- Fair round-robin arbitration, one access in flight, fixed-latency memory timing.
- Memory-side rw convention: rw=1 load (read), rw=0 store (write); cs=1 marks an active access.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for two requesters sharing one data-memory port; the arbiter takes
// the slave view, the requesters and memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          m0_req;
  logic          m0_rw;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_done;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_rw;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_done;
  logic [DW-1:0] m1_rdata;

  logic          mem_cs;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_rw, m0_addr, m0_wdata,
    input  m1_req, m1_rw, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_done, m0_rdata,
    output m1_gnt, m1_done, m1_rdata,
    output mem_cs, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_rw, m0_addr, m0_wdata,
    output m1_req, m1_rw, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_done, m0_rdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  mem_cs, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving two masters one fixed-latency memory port, one access in flight.
// Request to first cs is one cycle, cs held MEM_LAT cycles, then a 1-cycle done; losers simply wait with req held.
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_last, w_last_nxt;
  logic          r_sel, w_sel_nxt;
  logic [1:0]    r_gnt, w_gnt_nxt;
  logic [1:0]    r_done, w_done_nxt;
  logic          r_cs, w_cs_nxt;
  logic          r_rw, w_rw_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [DW-1:0] r_wdata, w_wdata_nxt;
  logic [DW-1:0] r_rdata0, w_rdata0_nxt;
  logic [DW-1:0] r_rdata1, w_rdata1_nxt;
  logic          w_pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_last starts at 1 so master 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_sel    <= 1'b0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_cs     <= 1'b0;
      r_rw     <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_last   <= w_last_nxt;
      r_sel    <= w_sel_nxt;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_cs     <= w_cs_nxt;
      r_rw     <= w_rw_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_last_nxt   = r_last;
    w_sel_nxt    = r_sel;
    w_gnt_nxt    = r_gnt;
    w_done_nxt   = r_done;
    w_cs_nxt     = r_cs;
    w_rw_nxt     = r_rw;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
    w_pick       = (bus.m0_req && bus.m1_req) ? ~r_last : bus.m1_req;

    case (r_state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          w_sel_nxt   = w_pick;
          w_rw_nxt    = w_pick ? bus.m1_rw    : bus.m0_rw;
          w_addr_nxt  = w_pick ? bus.m1_addr  : bus.m0_addr;
          w_wdata_nxt = w_pick ? bus.m1_wdata : bus.m0_wdata;
          w_gnt_nxt   = w_pick ? 2'b10 : 2'b01;
          w_cs_nxt    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt == LAST_CNT) begin
          // Memory data is only valid on the final cs cycle.
          if (r_rw) begin
            if (r_sel) w_rdata1_nxt = bus.mem_rdata;
            else       w_rdata0_nxt = bus.mem_rdata;
          end
          w_cs_nxt    = 1'b0;
          w_done_nxt  = r_sel ? 2'b10 : 2'b01;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DONE: begin
        w_done_nxt  = '0;
        w_gnt_nxt   = '0;
        w_last_nxt  = r_sel;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        w_cs_nxt    = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.m0_gnt    = r_gnt[0];
  assign bus.m1_gnt    = r_gnt[1];
  assign bus.m0_done   = r_done[0];
  assign bus.m1_done   = r_done[1];
  assign bus.m0_rdata  = r_rdata0;
  assign bus.m1_rdata  = r_rdata1;
  assign bus.mem_cs    = r_cs;
  assign bus.mem_rw    = r_rw;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

endmodule
